// File: rtl/bcd_addsub_serial.sv
// Serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           request an operation (sampled only in IDLE)
//   i_sub             0 = A+B, 1 = A-B via ten's complement (latched on start)
//   i_cin             decimal carry-in (latched on start)
//   i_a, i_b          packed BCD operands, digit 0 in [3:0] (latched on start)
//   o_busy            operation in progress
//   o_done            one-cycle pulse, results valid
//   o_sum             packed BCD result
//   o_cout            final decimal carry (sub mode: 1 = no borrow)
//   o_invalid         a latched operand digit exceeded 9
module bcd_addsub_serial #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_sub,
  input  logic                  i_cin,
  input  logic [4*DIGITS-1:0]   i_a,
  input  logic [4*DIGITS-1:0]   i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_sum,
  output logic                  o_cout,
  output logic                  o_invalid
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_n;
  logic [W-1:0]     r_a, w_a_n;
  logic [W-1:0]     r_b, w_b_n;
  logic             r_sub, w_sub_n;
  logic             r_carry, w_carry_n;
  logic [IDX_W-1:0] r_idx, w_idx_n;
  logic [W-1:0]     r_sum, w_sum_n;
  logic             r_cout, w_cout_n;
  logic             r_invalid, w_invalid_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;

  logic [3:0]       w_a_dig;
  logic [3:0]       w_b_dig;
  logic [3:0]       w_bd;
  logic [4:0]       w_z;
  logic [3:0]       w_sum_dig;
  logic             w_carry_out;
  logic             w_in_invalid;

  // Any incoming digit above 9 in either operand
  always_comb begin
    w_in_invalid = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (i_a[4*k +: 4] > 4'd9) w_in_invalid = 1'b1;
      if (i_b[4*k +: 4] > 4'd9) w_in_invalid = 1'b1;
    end
  end

  // Single shared digit adder with decimal correction
  always_comb begin
    w_a_dig = r_a[4*r_idx +: 4];
    w_b_dig = r_b[4*r_idx +: 4];
    // nine's complement of B; modulo-16 keeps invalid digits deterministic
    w_bd    = r_sub ? 4'(4'd9 - w_b_dig) : w_b_dig;
    w_z     = 5'(w_a_dig) + 5'(w_bd) + 5'(r_carry);
    if (w_z > 5'd9) begin
      w_sum_dig   = 4'(w_z + 5'd6);
      w_carry_out = 1'b1;
    end else begin
      w_sum_dig   = w_z[3:0];
      w_carry_out = 1'b0;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_n   = r_state;
    w_a_n       = r_a;
    w_b_n       = r_b;
    w_sub_n     = r_sub;
    w_carry_n   = r_carry;
    w_idx_n     = r_idx;
    w_sum_n     = r_sum;
    w_cout_n    = r_cout;
    w_invalid_n = r_invalid;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_a_n       = i_a;
          w_b_n       = i_b;
          w_sub_n     = i_sub;
          w_carry_n   = i_cin;
          w_idx_n     = '0;
          w_sum_n     = '0;
          w_invalid_n = w_in_invalid;
          w_busy_n    = 1'b1;
          w_state_n   = S_RUN;
        end
      end
      S_RUN: begin
        w_sum_n[4*r_idx +: 4] = w_sum_dig;
        w_carry_n             = w_carry_out;
        w_idx_n               = IDX_W'(r_idx + 1'b1);
        if (r_idx == LAST_IDX) begin
          w_idx_n   = '0;
          w_cout_n  = w_carry_out;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_invalid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_a       <= w_a_n;
      r_b       <= w_b_n;
      r_sub     <= w_sub_n;
      r_carry   <= w_carry_n;
      r_idx     <= w_idx_n;
      r_sum     <= w_sum_n;
      r_cout    <= w_cout_n;
      r_invalid <= w_invalid_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_sum     = r_sum;
  assign o_cout    = r_cout;
  assign o_invalid = r_invalid;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed bench for bcd_addsub_serial with DIGITS=4.
module tb_bcd_addsub_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, invalid;
  logic [15:0] sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_addsub_serial #(.DIGITS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub), .i_cin(cin),
    .i_a(a), .i_b(b), .o_busy(busy), .o_done(done), .o_sum(sum),
    .o_cout(cout), .o_invalid(invalid)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_inv;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive operands with start high, ahead of the next rising edge.
  task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vs, input logic vc);
    @(negedge clk);
    a = va; b = vb; sub = vs; cin = vc; start = 1'b1;
  endtask

  // Take the accepting edge, then wait for done and check the result.
  task automatic finish_op(input vec_t v);
    int lat;
    int bc;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
    chk({v.name, " latency"}, 32'(lat), 32'd4);
    chk({v.name, " busy_cycles"}, 32'(bc), 32'd4);
    chk({v.name, " sum"}, 32'(sum), 32'(v.exp_sum));
    chk({v.name, " cout"}, 32'(cout), 32'(v.exp_cout));
    chk({v.name, " invalid"}, 32'(invalid), 32'(v.exp_inv));
  endtask

  initial begin
    vec_t v;
    int   lat;
    bit   saw_done;

    vecs[0] = '{"add_basic",   16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"add_wrap",    16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_wrap_ci", 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{"sub_pos",     16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0};
    vecs[4] = '{"sub_neg",     16'h1234, 16'h5000, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0};
    vecs[5] = '{"sub_zero",    16'h0042, 16'h0042, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{"add_inv",     16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h1305, 1'b0, 1'b1};
    vecs[7] = '{"add_max",     16'h9999, 16'h9999, 1'b0, 1'b0, 16'h9998, 1'b1, 1'b0};
    vecs[8] = '{"sub_borrow",  16'h0000, 16'h0001, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};

    // reset state
    #12;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst sum", 32'(sum), 0);
    chk("rst cout", 32'(cout), 0);
    chk("rst invalid", 32'(invalid), 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      finish_op(vecs[i]);
    end

    // done is a single-cycle pulse and results hold in IDLE
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 0);
    @(posedge clk); #1;
    chk("hold sum", 32'(sum), 32'h9999);
    chk("hold cout", 32'(cout), 0);

    // start pulsed while busy is ignored
    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; a = 16'h9999; b = 16'h9999; sub = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore latency", 32'(lat), 4);
    chk("ignore sum", 32'(sum), 32'h6912);
    chk("ignore cout", 32'(cout), 0);
    @(posedge clk); #1;
    chk("ignore no_restart", 32'(busy), 0);

    // back-to-back: start held during the done cycle
    launch(16'h0005, 16'h0007, 1'b0, 1'b0);
    v = '{"b2b_first", 16'h0005, 16'h0007, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0};
    finish_op(v);
    a = 16'h4321; b = 16'h1111; sub = 1'b1; cin = 1'b1; start = 1'b1;
    v = '{"b2b_second", 16'h4321, 16'h1111, 1'b1, 1'b1, 16'h3210, 1'b1, 1'b0};
    finish_op(v);

    // asynchronous reset while digit 2 is being processed
    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 0);
    chk("arst done", 32'(done), 0);
    chk("arst sum", 32'(sum), 0);
    chk("arst cout", 32'(cout), 0);
    chk("arst invalid", 32'(invalid), 0);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("arst no_done", 32'(saw_done), 0);
    launch(16'h0005, 16'h0005, 1'b0, 1'b0);
    v = '{"after_rst", 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    finish_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
